dmem_responder: RTL and testbench

Data-memory responder for the 5-stage pipeline: the target end of the load/store request interface issued by the memory stage. It accepts one request at a time, performs RISC-V byte/half/word access with byte lanes and sign/zero extension, and returns a response after a configurable number of wait cycles. Misaligned, out-of-range and illegal-size requests are flagged with an error instead of touching memory. The storage array is visible hierarchically so benches can dump data memory at end of program.

---
 rtl/dmem_responder_pkg.sv | 35 +++
 rtl/dm_ram.sv | 28 ++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder.
// Size codes, FSM states, counter width, byte-lane helper.
package dmem_responder_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] lane_mask(
    input size_e      sz,
    input logic [1:0] lane
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      sz == SZ_B: m = 4'b0001 << lane;
      sz == SZ_H: m = lane[1] ? 4'b1100 : 4'b0011;
      sz == SZ_W: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-wide data array with per-byte write enables.
// clk; addr word index; be/wdata write; re/rdata captured read.
module dm_ram
  #(parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH))
  (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] RAM [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        RAM[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata <= RAM[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one request at a time, byte/half/word access.
// CLK/RST; REQ_* request with REQ_RDY; RSP_V/RSP_RDATA/RSP_ERR reply.
module dmem_responder
  import dmem_responder_pkg::*;
  #(parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int          LATENCY = 1)
  (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_V,
  output logic        REQ_RDY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNS,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_V,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input size_e       sz,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      sz == SZ_B: r = {{24{~uns & b[7]}}, b};
      sz == SZ_H: r = {{16{~uns & h[15]}}, h};
      default:    r = w;
    endcase
    return r;
  endfunction

  state_e          state, nstate;
  logic [LAT_W-1:0] cnt, ncnt;

  size_e       size;
  logic        acc;
  logic [32:0] off;
  logic        oob;
  logic        misal;
  logic        bad;
  logic [3:0]  be;
  logic        re;
  logic [31:0] wrep;
  logic [31:0] rd_word;

  logic [1:0]  lane_q;
  size_e       size_q;
  logic        uns_q;
  logic        err_q;
  logic        ld_q;

  assign size = size_e'(REQ_SIZE);
  assign acc  = REQ_V && (state == IDLE);

  // 33-bit offset: a borrow below BASE lands above SPAN
  assign off = {1'b0, REQ_ADDR} - {1'b0, BASE};
  assign oob = off >= SPAN;

  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      size == SZ_H:   misal = REQ_ADDR[0];
      size == SZ_W:   misal = |REQ_ADDR[1:0];
      size == SZ_BAD: misal = 1'b1;
      default:        misal = 1'b0;
    endcase
  end

  assign bad = oob | misal;
  assign be  = (acc && REQ_WE && !bad)
             ? lane_mask(size, REQ_ADDR[1:0]) : 4'b0000;
  assign re  = acc && !REQ_WE && !bad;

  // replicate so the enabled lanes see the right-justified data
  always_comb begin
    wrep = REQ_WDATA;
    unique case (1'b1)
      size == SZ_B: wrep = {4{REQ_WDATA[7:0]}};
      size == SZ_H: wrep = {2{REQ_WDATA[15:0]}};
      default:      wrep = REQ_WDATA;
    endcase
  end

  dm_ram #(.DEPTH(DEPTH), .AW(AW)) DM (
    .clk   (CLK),
    .addr  (off[AW+1:2]),
    .be    (be),
    .wdata (wrep),
    .re    (re),
    .rdata (rd_word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      lane_q <= 2'b00;
      size_q <= SZ_B;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      ld_q   <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (acc) begin
        lane_q <= REQ_ADDR[1:0];
        size_q <= size;
        uns_q  <= REQ_UNS;
        err_q  <= bad;
        ld_q   <= !REQ_WE && !bad;
      end
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    unique case (state)
      IDLE: begin
        if (REQ_V) begin
          if (LATENCY == 1) begin
            nstate = RESP;
          end else begin
            nstate = WAIT;
            ncnt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == LAT_W'(1)) begin
          nstate = RESP;
          ncnt   = '0;
        end else begin
          ncnt = cnt - LAT_W'(1);
        end
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign REQ_RDY   = (state == IDLE);
  assign RSP_V     = (state == RESP);
  assign RSP_ERR   = RSP_V && err_q;
  assign RSP_RDATA = (RSP_V && ld_q)
                   ? load_ext(rd_word, lane_q, size_q, uns_q)
                   : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 1, 4 and 3.
// Three instances share one clock; each test drives one of them.
module tb_dmem_responder;

  logic        clk;
  logic        rst       [3];
  logic        req_v     [3];
  logic        req_rdy   [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [1:0]  req_size  [3];
  logic        req_uns   [3];
  logic [31:0] req_wdata [3];
  logic        rsp_v     [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int nvec;
  int nmis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .BASE(32'h0), .LATENCY(1)) u_l1 (
    .CLK(clk), .RST(rst[0]), .REQ_V(req_v[0]), .REQ_RDY(req_rdy[0]),
    .REQ_WE(req_we[0]), .REQ_ADDR(req_addr[0]), .REQ_SIZE(req_size[0]),
    .REQ_UNS(req_uns[0]), .REQ_WDATA(req_wdata[0]), .RSP_V(rsp_v[0]),
    .RSP_RDATA(rsp_rdata[0]), .RSP_ERR(rsp_err[0])
  );

  dmem_responder #(.DEPTH(1024), .BASE(32'h0), .LATENCY(4)) u_l4 (
    .CLK(clk), .RST(rst[1]), .REQ_V(req_v[1]), .REQ_RDY(req_rdy[1]),
    .REQ_WE(req_we[1]), .REQ_ADDR(req_addr[1]), .REQ_SIZE(req_size[1]),
    .REQ_UNS(req_uns[1]), .REQ_WDATA(req_wdata[1]), .RSP_V(rsp_v[1]),
    .RSP_RDATA(rsp_rdata[1]), .RSP_ERR(rsp_err[1])
  );

  dmem_responder #(.DEPTH(1024), .BASE(32'h0), .LATENCY(3)) u_l3 (
    .CLK(clk), .RST(rst[2]), .REQ_V(req_v[2]), .REQ_RDY(req_rdy[2]),
    .REQ_WE(req_we[2]), .REQ_ADDR(req_addr[2]), .REQ_SIZE(req_size[2]),
    .REQ_UNS(req_uns[2]), .REQ_WDATA(req_wdata[2]), .RSP_V(rsp_v[2]),
    .RSP_RDATA(rsp_rdata[2]), .RSP_ERR(rsp_err[2])
  );

  task automatic xfer(
    input  int          i,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int n;
    @(negedge clk);
    req_v[i]     = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_size[i]  = sz;
    req_uns[i]   = uns;
    req_wdata[i] = wd;
    n = 0;
    while (!req_rdy[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_v[i] = 1'b0;
    lat = 0;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_v[i]) begin
        lat = k;
        rd  = rsp_rdata[i];
        er  = rsp_err[i];
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req_v[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_size[i] = 2'd0; req_uns[i] = 1'b0;
      req_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (req_rdy[i] !== 1'b1 || rsp_v[i] !== 1'b0 ||
          rsp_rdata[i] !== 32'h0 || rsp_err[i] !== 1'b0) begin
        nmis++;
        $display("FAIL reset[%0d]: rdy=%b v=%b rd=%h err=%b want 1 0 0 0",
                 i, req_rdy[i], rsp_v[i], rsp_rdata[i], rsp_err[i]);
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  task automatic run_vecs(input int i, input int exp_lat, input vec_t v[$]);
    logic [31:0] rd;
    logic        er;
    int          lat;
    foreach (v[j]) begin
      xfer(i, v[j].we, v[j].a, v[j].sz, v[j].uns, v[j].wd, rd, er, lat);
      nvec++;
      if (lat !== exp_lat || er !== v[j].exp_er || rd !== v[j].exp_rd) begin
        nmis++;
        $display("FAIL %s: lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                 v[j].name, lat, er, rd, exp_lat, v[j].exp_er, v[j].exp_rd);
      end
    end
  endtask

  task automatic test_word;
    vec_t v[$];
    v.push_back('{"sw_100", 1, 32'h100, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0});
    v.push_back('{"lw_100", 0, 32'h100, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0});
    run_vecs(0, 1, v);
  endtask

  task automatic test_byte;
    vec_t v[$];
    v.push_back('{"sw_zero", 1, 32'h100, 2'd2, 0, 32'h0, 32'h0, 0});
    v.push_back('{"sb_101", 1, 32'h101, 2'd0, 0, 32'hFFFF_FF80, 32'h0, 0});
    v.push_back('{"lb_101", 0, 32'h101, 2'd0, 0, 32'h0, 32'hFFFFFF80, 0});
    v.push_back('{"lbu_101", 0, 32'h101, 2'd0, 1, 32'h0, 32'h00000080, 0});
    v.push_back('{"lw_after_sb", 0, 32'h100, 2'd2, 0, 32'h0, 32'h00008000, 0});
    run_vecs(0, 1, v);
  endtask

  task automatic test_half;
    vec_t v[$];
    v.push_back('{"sh_102", 1, 32'h102, 2'd1, 0, 32'h1234_8001, 32'h0, 0});
    v.push_back('{"lh_102", 0, 32'h102, 2'd1, 0, 32'h0, 32'hFFFF8001, 0});
    v.push_back('{"lhu_102", 0, 32'h102, 2'd1, 1, 32'h0, 32'h00008001, 0});
    v.push_back('{"lh_103_misal", 0, 32'h103, 2'd1, 0, 32'h0, 32'h0, 1});
    v.push_back('{"sh_103_misal", 1, 32'h103, 2'd1, 0, 32'hFFFF, 32'h0, 1});
    v.push_back('{"sw_102_misal", 1, 32'h102, 2'd2, 0, 32'hFFFF_FFFF, 32'h0, 1});
    v.push_back('{"lw_after_sh", 0, 32'h100, 2'd2, 0, 32'h0, 32'h80018000, 0});
    v.push_back('{"lb_103", 0, 32'h103, 2'd0, 0, 32'h0, 32'hFFFFFF80, 0});
    run_vecs(0, 1, v);
  endtask

  task automatic test_bounds;
    vec_t v[$];
    v.push_back('{"sw_0", 1, 32'h0, 2'd2, 0, 32'h11111111, 32'h0, 0});
    v.push_back('{"sw_top_oob", 1, 32'h1000, 2'd2, 0, 32'h22222222, 32'h0, 1});
    v.push_back('{"lw_top_oob", 0, 32'h1000, 2'd2, 0, 32'h0, 32'h0, 1});
    v.push_back('{"sz3_store", 1, 32'h100, 2'd3, 0, 32'hFFFFFFFF, 32'h0, 1});
    v.push_back('{"sw_last", 1, 32'hFFC, 2'd2, 0, 32'hCAFEF00D, 32'h0, 0});
    v.push_back('{"lw_last", 0, 32'hFFC, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0});
    run_vecs(0, 1, v);
    nvec++;
    if (u_l1.DM.RAM[0] !== 32'h11111111) begin
      nmis++;
      $display("FAIL ram0_after_oob: got %h want %h",
               u_l1.DM.RAM[0], 32'h11111111);
    end
    nvec++;
    if (u_l1.DM.RAM[64] !== 32'h80018000) begin
      nmis++;
      $display("FAIL ram64_after_sz3: got %h want %h",
               u_l1.DM.RAM[64], 32'h80018000);
    end
  endtask

  task automatic test_latency;
    vec_t v[$];
    int nresp;
    @(negedge clk);
    req_v[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h0;
    req_size[1] = 2'd2; req_uns[1] = 1'b0; req_wdata[1] = 32'hA5A50F0F;
    @(posedge clk);
    nresp = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (rsp_v[1]) nresp++;
      nvec++;
      if (req_rdy[1] !== 1'b0 || rsp_v[1] !== (c == 4)) begin
        nmis++;
        $display("FAIL lat4_cycle%0d: rdy=%b v=%b want rdy=0 v=%b",
                 c, req_rdy[1], rsp_v[1], (c == 4));
      end
      @(posedge clk);
    end
    #1;
    nvec++;
    if (req_rdy[1] !== 1'b1 || rsp_v[1] !== 1'b0) begin
      nmis++;
      $display("FAIL lat4_idle: rdy=%b v=%b want 1 0", req_rdy[1], rsp_v[1]);
    end
    req_v[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (rsp_v[1]) nresp++;
    end
    nvec++;
    if (nresp !== 1) begin
      nmis++;
      $display("FAIL lat4_single_accept: responses=%0d want 1", nresp);
    end
    v.push_back('{"lat4_lw_0", 0, 32'h0, 2'd2, 0, 32'h0, 32'hA5A50F0F, 0});
    v.push_back('{"lat4_lhu_2", 0, 32'h2, 2'd1, 1, 32'h0, 32'h0000A5A5, 0});
    run_vecs(1, 4, v);
  endtask

  task automatic test_reset_mid;
    vec_t v[$];
    int nresp;
    @(negedge clk);
    req_v[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h8;
    req_size[2] = 2'd2; req_uns[2] = 1'b0; req_wdata[2] = 32'h12345678;
    @(posedge clk);
    #1;
    req_v[2] = 1'b0;
    rst[2] = 1'b1;
    #1;
    nvec++;
    if (req_rdy[2] !== 1'b1 || rsp_v[2] !== 1'b0) begin
      nmis++;
      $display("FAIL rst_mid_async: rdy=%b v=%b want 1 0",
               req_rdy[2], rsp_v[2]);
    end
    @(negedge clk);
    rst[2] = 1'b0;
    nresp = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (rsp_v[2]) nresp++;
    end
    nvec++;
    if (nresp !== 0 || req_rdy[2] !== 1'b1) begin
      nmis++;
      $display("FAIL rst_mid_dropped: responses=%0d rdy=%b want 0 1",
               nresp, req_rdy[2]);
    end
    v.push_back('{"rst_mid_lw_8", 0, 32'h8, 2'd2, 0, 32'h0, 32'h12345678, 0});
    run_vecs(2, 3, v);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_bounds();
    test_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
